// File: rtl/serial_adder_nibbles.sv
// Multi-cycle adder: adds one 4-bit nibble pair per clock, LSB first,
// with a registered carry, and produces a (4*NIBBLES+1)-bit result.
module serial_adder_nibbles #(
    parameter int NIBBLES = 4
) (
    input  logic                 i_w_clk,
    input  logic                 i_w_rst_n,
    input  logic                 i_w_start,
    input  logic [4*NIBBLES-1:0] i_w_a,
    input  logic [4*NIBBLES-1:0] i_w_b,
    output logic [4*NIBBLES:0]   o_w_s,
    output logic                 o_w_busy,
    output logic                 o_w_done
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    // state   | meaning
    // IDLE    | waiting for start; operands captured on start
    // RUN     | one nibble slice added per cycle
    // DONE    | accumulator copied to the result, done pulsed
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W:0]    acc_q, acc_d;
    logic [W:0]    s_q, s_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          done_q, done_d;

    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [4:0]    sum;

    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Constant-index slice select keeps the mux free of variable part-selects.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
        sum = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_w_start) begin
                    a_d     = i_w_a;
                    b_d     = i_w_b;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IW'(i)) acc_d[4*i +: 4] = sum[3:0];
                end
                carry_d = sum[4];
                if (idx_q == LAST) begin
                    acc_d[W] = sum[4];
                    idx_d    = '0;
                    state_d  = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                s_d     = acc_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_w_s    = s_q;
    assign o_w_busy = (state_q != ST_IDLE);
    assign o_w_done = done_q;

endmodule
